// File: rtl/sub_float16_seq.sv
// Multi-cycle fp16 subtractor (data1 - data2) with iterative normalization.
// Simplified fp16: no denormals/NaN/Inf, saturate on overflow, flush on underflow.
module sub_float16_seq #(
  parameter int NORM_STEP = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        ovf,
  output logic        unf
);

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t      r_state;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_max;
  logic [22:0] r_frac;
  logic [3:0]  r_cnt;
  logic        r_zmin;
  logic        r_cancel;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [15:0] r_result;
  logic        r_ovf;
  logic        r_unf;

  logic        w_a_is_max;
  logic [15:0] w_max;
  logic [15:0] w_min;
  logic [4:0]  w_diff;
  logic [22:0] w_max_sig;
  logic [22:0] w_min_sig;
  logic [22:0] w_min_shf;
  logic [22:0] w_frac;

  // Operand ordering by magnitude; a tie keeps data1 as the larger one.
  assign w_a_is_max = (r_a[14:0] >= r_b[14:0]);
  assign w_max      = w_a_is_max ? r_a : r_b;
  assign w_min      = w_a_is_max ? r_b : r_a;
  assign w_diff     = w_max[14:10] - w_min[14:10];
  assign w_max_sig  = {2'b01, w_max[9:0], 11'b0};
  assign w_min_sig  = {2'b01, w_min[9:0], 11'b0};
  assign w_min_shf  = w_min_sig >> w_diff;
  assign w_frac     = (w_max[15] == w_min[15]) ? (w_max_sig + w_min_shf)
                                               : (w_max_sig - w_min_shf);

  logic [4:0] w_lz;
  logic [3:0] w_step;
  logic       w_norm_done;

  always_comb begin
    w_lz = 5'd22;
    for (int i = 0; i < 22; i++) begin
      if (r_frac[i]) w_lz = 5'(21 - i);
    end
  end

  assign w_step      = (w_lz < 5'(NORM_STEP)) ? w_lz[3:0] : 4'(NORM_STEP);
  assign w_norm_done = r_zmin | r_cancel | (r_frac[22:21] != 2'b00) | (r_cnt >= 4'd11);

  logic [11:0]       w_r;
  logic signed [6:0] w_e;
  logic [9:0]        w_mant;
  logic [15:0]       w_res;
  logic              w_ovf;
  logic              w_unf;

  // Cancellation takes priority over a zero minor operand so that x - x is always +0.
  always_comb begin
    w_r    = r_frac[22:11] + {11'b0, r_frac[10]};
    w_e    = $signed({2'b00, r_max[14:10]}) - $signed({3'b000, r_cnt})
           + $signed({6'b0, w_r[11]});
    w_mant = w_r[11] ? w_r[10:1] : w_r[9:0];
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    if (r_cancel) begin
      w_res = 16'h0000;
    end else if (r_zmin) begin
      w_res = r_max;
    end else if (w_e >= 7'sd31) begin
      w_res = {r_max[15], 5'b11110, 10'h3FF};
      w_ovf = 1'b1;
    end else if (w_e <= 7'sd0) begin
      w_res = {r_max[15], 15'b0};
      w_unf = 1'b1;
    end else begin
      w_res = {r_max[15], w_e[4:0], w_mant};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= 16'h0000;
      r_b         <= 16'h0000;
      r_max       <= 16'h0000;
      r_frac      <= 23'd0;
      r_cnt       <= 4'd0;
      r_zmin      <= 1'b0;
      r_cancel    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= 16'h0000;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= data1;
            r_b        <= {~data2[15], data2[14:0]};
            r_in_ready <= 1'b0;
            r_state    <= ALIGN;
          end
        end
        ALIGN: begin
          r_max    <= w_max;
          r_frac   <= w_frac;
          r_cnt    <= 4'd0;
          r_zmin   <= (w_min[14:0] == 15'd0);
          r_cancel <= (w_max[15] != w_min[15]) && (w_max[14:0] == w_min[14:0]);
          r_state  <= NORM;
        end
        NORM: begin
          if (w_norm_done) begin
            r_state <= ROUND;
          end else begin
            r_frac <= r_frac << w_step;
            r_cnt  <= r_cnt + w_step;
          end
        end
        ROUND: begin
          r_result    <= w_res;
          r_ovf       <= w_ovf;
          r_unf       <= w_unf;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule

// File: tb/tb_sub_float16_seq.sv
// Bench for sub_float16_seq: two instances (NORM_STEP 1 and 2) share stimulus and are
// checked every cycle against an integer-arithmetic model of the fp16 subtract rules.
module tb_sub_float16_seq;

  localparam int PERIOD = 10;
  localparam int HALF   = 5;
  localparam int SAMP   = 2;
  localparam int ND     = 8;

  localparam logic [15:0] DIR_A [ND] = '{16'h3C00, 16'h3C00, 16'h4200, 16'h0000,
                                         16'h7BFF, 16'h3C01, 16'h0402, 16'h5123};
  localparam logic [15:0] DIR_B [ND] = '{16'h3800, 16'hBC00, 16'h4200, 16'h3C00,
                                         16'hFBFF, 16'h3C00, 16'h0401, 16'h8000};
  localparam logic [15:0] DIR_R [ND] = '{16'h3800, 16'h4000, 16'h0000, 16'hBC00,
                                         16'h7BFF, 16'h1400, 16'h0000, 16'h5123};
  localparam logic        DIR_O [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic        DIR_U [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam int          DIR_N [ND] = '{1, 0, 0, 0, 0, 10, 10, 0};

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             out_ready;
  logic [15:0]      data1;
  logic [15:0]      data2;
  logic [1:0]       inReady;
  logic [1:0]       outValid;
  logic [1:0]       ovfV;
  logic [1:0]       unfV;
  logic [1:0][15:0] resultV;

  int          nCompared;
  int          nMismatch;
  logic [1:0]  pending;
  logic [1:0]  prevValid;
  time         tAccept [2];
  logic [15:0] expRes;
  logic        expOvf;
  logic        expUnf;
  int          expN;

  sub_float16_seq #(.NORM_STEP(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady[0]),
    .data1(data1), .data2(data2), .out_valid(outValid[0]), .out_ready(out_ready),
    .result(resultV[0]), .ovf(ovfV[0]), .unf(unfV[0])
  );

  sub_float16_seq #(.NORM_STEP(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReady[1]),
    .data1(data1), .data2(data2), .out_valid(outValid[1]), .out_ready(out_ready),
    .result(resultV[1]), .ovf(ovfV[1]), .unf(unfV[1])
  );

  initial clk = 1'b0;
  always #(HALF) clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: magnitude-ordered integer add/subtract, normalize, round half-up.
  function automatic void model(input logic [15:0] d1, input logic [15:0] d2,
                                output logic [15:0] res, output logic ov,
                                output logic un, output int n);
    logic [15:0] b, mx, mn;
    int fmax, fmin, frac, e, r, sh, mant;
    b  = {~d2[15], d2[14:0]};
    ov = 1'b0;
    un = 1'b0;
    n  = 0;
    if (d1[14:0] >= b[14:0]) begin
      mx = d1;
      mn = b;
    end else begin
      mx = b;
      mn = d1;
    end
    if (mx[15] != mn[15] && mx[14:0] == mn[14:0]) begin
      res = 16'h0000;
      return;
    end
    if (mn[14:0] == 15'd0) begin
      res = mx;
      return;
    end
    sh   = int'(mx[14:10]) - int'(mn[14:10]);
    fmax = (1024 + int'(mx[9:0])) * 2048;
    fmin = ((1024 + int'(mn[9:0])) * 2048) >> sh;
    frac = (mx[15] == mn[15]) ? fmax + fmin : fmax - fmin;
    while (frac < (1 << 21) && n < 11) begin
      frac = frac * 2;
      n++;
    end
    r = (frac >> 11) + ((frac >> 10) & 1);
    e = int'(mx[14:10]) - n;
    if (r >= 2048) begin
      e++;
      mant = (r >> 1) & 1023;
    end else begin
      mant = r & 1023;
    end
    if (e >= 31) begin
      res = {mx[15], 5'b11110, 10'h3FF};
      ov  = 1'b1;
    end else if (e <= 0) begin
      res = {mx[15], 15'b0};
      un  = 1'b1;
    end else begin
      res = {mx[15], 5'(e), 10'(mant)};
    end
  endfunction

  task automatic monitor();
    int  lat;
    int  stepK;
    bit  acc;
    forever begin
      @(negedge clk);
      #(SAMP);
      if (rst) begin
        pending   = '0;
        prevValid = '0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          stepK = k + 1;
          checkOutput($sformatf("in_ready[%0d]", k), int'(inReady[k]), int'(!pending[k]));
          if (outValid[k]) begin
            checkOutput($sformatf("valid_without_op[%0d]", k), int'(pending[k]), 1);
            checkOutput($sformatf("result[%0d]", k), int'(resultV[k]), int'(expRes));
            checkOutput($sformatf("ovf[%0d]", k), int'(ovfV[k]), int'(expOvf));
            checkOutput($sformatf("unf[%0d]", k), int'(unfV[k]), int'(expUnf));
            if (!prevValid[k]) begin
              lat = int'(($time - HALF - SAMP - tAccept[k]) / PERIOD);
              checkOutput($sformatf("latency[%0d]", k), lat, 3 + (expN + stepK - 1) / stepK);
            end
          end
          acc = in_valid && !pending[k];
          if (outValid[k] && out_ready) pending[k] = 1'b0;
          if (acc) begin
            pending[k]  = 1'b1;
            tAccept[k]  = $time + HALF - SAMP;
          end
          prevValid[k] = outValid[k];
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d1, input logic [15:0] d2,
                               input logic [15:0] eRes, input logic eO, input logic eU,
                               input int eN, input int hold, input bit junk);
    int g;
    g = 0;
    do begin
      @(negedge clk);
      #1;
      g++;
    end while (inReady != 2'b11 && g < 400);
    checkOutput("wait_idle", int'(inReady), 3);
    expRes    = eRes;
    expOvf    = eO;
    expUnf    = eU;
    expN      = eN;
    data1     = d1;
    data2     = d2;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    data1    = 16'($urandom);
    data2    = 16'($urandom);
    if (hold > 0) begin
      g = 0;
      while (outValid != 2'b11 && g < 400) begin
        @(negedge clk);
        #1;
        g++;
      end
      checkOutput("wait_valid", int'(outValid), 3);
      for (int i = 0; i < hold; i++) begin
        in_valid = junk;
        data1    = 16'h1234;
        data2    = 16'h0101;
        @(negedge clk);
        #1;
        checkOutput("hold_out_valid", int'(outValid), 3);
        checkOutput("hold_in_ready", int'(inReady), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    g = 0;
    while (pending != 2'b00 && g < 400) begin
      @(negedge clk);
      #1;
      g++;
    end
    checkOutput("wait_done", int'(pending), 0);
  endtask

  task automatic resetMidNorm();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      #1;
      g++;
    end while (inReady != 2'b11 && g < 400);
    expRes   = 16'h1400;
    expOvf   = 1'b0;
    expUnf   = 1'b0;
    expN     = 10;
    data1    = 16'h3C01;
    data2    = 16'h3C00;
    in_valid = 1'b1;
    @(negedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_out_valid", int'(outValid), 0);
    checkOutput("rst_mid_in_ready", int'(inReady), 3);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    checkOutput("rst_mid_no_stale_valid", int'(outValid), 0);
    checkOutput("rst_mid_idle_after", int'(inReady), 3);
  endtask

  initial begin
    logic [15:0] a, b, mRes;
    logic        mO, mU;
    int          mN, mode, hold;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data1     = 16'h0000;
    data2     = 16'h0000;
    pending   = '0;
    prevValid = '0;
    nCompared = 0;
    nMismatch = 0;
    expRes    = 16'h0000;
    expOvf    = 1'b0;
    expUnf    = 1'b0;
    expN      = 0;
    fork
      monitor();
    join_none

    #2;
    checkOutput("reset_out_valid", int'(outValid), 0);
    checkOutput("reset_in_ready", int'(inReady), 3);
    checkOutput("reset_result0", int'(resultV[0]), 0);
    checkOutput("reset_result1", int'(resultV[1]), 0);
    checkOutput("reset_ovf", int'(ovfV), 0);
    checkOutput("reset_unf", int'(unfV), 0);

    for (int i = 0; i < ND; i++) begin
      model(DIR_A[i], DIR_B[i], mRes, mO, mU, mN);
      checkOutput($sformatf("model_res[%0d]", i), int'(mRes), int'(DIR_R[i]));
      checkOutput($sformatf("model_ovf[%0d]", i), int'(mO), int'(DIR_O[i]));
      checkOutput($sformatf("model_unf[%0d]", i), int'(mU), int'(DIR_U[i]));
      checkOutput($sformatf("model_n[%0d]", i), mN, DIR_N[i]);
    end

    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < ND; i++) begin
      applyStimulus(DIR_A[i], DIR_B[i], DIR_R[i], DIR_O[i], DIR_U[i], DIR_N[i], 0, 1'b0);
    end

    applyStimulus(16'h3C01, 16'h3C00, 16'h1400, 1'b0, 1'b0, 10, 5, 1'b1);
    applyStimulus(16'h7BFF, 16'hFBFF, 16'h7BFF, 1'b1, 1'b0, 0, 5, 1'b1);

    resetMidNorm();
    applyStimulus(16'h3C01, 16'h3C00, 16'h1400, 1'b0, 1'b0, 10, 0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      mode = $urandom_range(0, 3);
      a    = 16'($urandom);
      case (mode)
        0: b = 16'($urandom);
        1: b = {1'($urandom), a[14:0] ^ 15'($urandom_range(0, 7))};
        2: b = a;
        default: b = {1'($urandom), a[14:10] - 5'($urandom_range(0, 2)), 10'($urandom)};
      endcase
      model(a, b, mRes, mO, mU, mN);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      applyStimulus(a, b, mRes, mO, mU, mN, hold, 1'($urandom));
    end

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
